// File: rtl/nios_io_ctrl_if.sv
// Pin-side and Nios-side signals of the dev-kit I/O conditioner.
// The master drives the raw pins and the Nios LED PIO value; the slave is the conditioner.
interface nios_io_ctrl_if;
    logic       key_0_raw_n;
    logic       key_1_raw_n;
    logic       switch_raw;
    logic       nios_led;
    logic       key_0_db_n;
    logic       key_1_db_n;
    logic       switch_db;
    logic       key_0_press;
    logic       key_1_press;
    logic       led_out;
    logic [1:0] led_mode;

    modport master (
        output key_0_raw_n, key_1_raw_n, switch_raw, nios_led,
        input  key_0_db_n, key_1_db_n, switch_db, key_0_press, key_1_press, led_out, led_mode
    );

    modport slave (
        input  key_0_raw_n, key_1_raw_n, switch_raw, nios_led,
        output key_0_db_n, key_1_db_n, switch_db, key_0_press, key_1_press, led_out, led_mode
    );
endinterface

// File: rtl/nios_io_ctrl.sv
// Board I/O conditioner: synchronises and debounces two keys and a switch for the Nios PIOs,
// and arbitrates the board LED between the Nios PIO, a heartbeat blinker and a switch mirror.
module nios_io_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned BLINK_HALF_PERIOD = 25000000,
    parameter int unsigned CNT_W             = 26
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    nios_io_ctrl_if.slave  io
);

    typedef enum logic [1:0] {
        StNios   = 2'd0,
        StBlink  = 2'd1,
        StSwitch = 2'd2
    } led_state_e;

    // Bit order everywhere: [0]=key 0 (active-low), [1]=key 1 (active-low), [2]=switch.
    localparam logic [2:0]       IdleVal   = 3'b011;
    localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_HALF_PERIOD - 1);

    logic [2:0]       w_raw;
    logic [2:0]       w_fire;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_db;
    logic [CNT_W-1:0] r_db_cnt [3];
    logic [1:0]       r_press;
    led_state_e       r_state;
    led_state_e       w_state_next;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic             r_led;

    assign w_raw = {io.switch_raw, io.key_1_raw_n, io.key_0_raw_n};

    // A debounced input flips when its synchronised value has disagreed for the whole window.
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < 3; i++) begin
            w_fire[i] = (r_sync2[i] != r_db[i]) && (r_db_cnt[i] == DbLast);
        end
    end

    // Two-flop synchronisers, per-input debounce counters and press pulses.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sync1 <= IdleVal;
            r_sync2 <= IdleVal;
            r_db    <= IdleVal;
            r_press <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_fire[i]) begin
                    r_db_cnt[i] <= '0;
                    r_db[i]     <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
            // Pulse only on the falling (press) edge of the debounced keys.
            r_press <= w_fire[1:0] & ~r_sync2[1:0];
        end
    end

    // LED owner state register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= StNios;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Key 1 cycles the owner, key 0 forces Nios and wins a tie; stray encoding recovers to Nios.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StNios:   if (r_press[1]) w_state_next = StBlink;
            StBlink:  if (r_press[1]) w_state_next = StSwitch;
            StSwitch: if (r_press[1]) w_state_next = StNios;
            default:  w_state_next = StNios;
        endcase
        if (r_press[0]) begin
            w_state_next = StNios;
        end
    end

    // Heartbeat: restarts with the LED lit on entry to blink mode, idles at zero otherwise.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_state_next == StBlink) begin
            if (r_state != StBlink) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
            end else if (r_blink_cnt == BlinkLast) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
        end else begin
            r_blink_cnt <= '0;
        end
    end

    // Registered LED drive from whichever source currently owns it.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_led <= 1'b0;
        end else begin
            case (r_state)
                StNios:   r_led <= io.nios_led;
                StBlink:  r_led <= r_phase;
                StSwitch: r_led <= r_db[2];
                default:  r_led <= 1'b0;
            endcase
        end
    end

    assign io.key_0_db_n  = r_db[0];
    assign io.key_1_db_n  = r_db[1];
    assign io.switch_db   = r_db[2];
    assign io.key_0_press = r_press[0];
    assign io.key_1_press = r_press[1];
    assign io.led_out     = r_led;
    assign io.led_mode    = r_state;

endmodule

// File: doc/nios_io_ctrl.md
Name: nios_io_ctrl

Overview:
Conditions the board push-buttons and slide switch before they reach the Nios PIO inputs (key_0, key_1, switch), and arbitrates the single board LED. The LED can be driven by three sources: the Nios LED PIO, a hardware heartbeat blinker, or a direct mirror of the switch. The block sits between the board pins and the Nios system instance, in the top-level of the dev-kit design.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced output changes (1 ms at 50 MHz); minimum 2
BLINK_HALF_PERIOD, 25000000, cycles per LED toggle in BLINK mode; minimum 1
CNT_W, 26, width of the debounce and blink counters; must hold max(DEBOUNCE_CYCLES, BLINK_HALF_PERIOD)

Ports:
clk_clk  input  1  system clock, same clock as the Nios system
reset_reset  input  1  synchronous, active-high reset
key_0_raw_n  input  1  raw push-button 0 from the pin, active-low, asynchronous
key_1_raw_n  input  1  raw push-button 1 from the pin, active-low, asynchronous
switch_raw  input  1  raw slide switch from the pin, asynchronous
nios_led  input  1  LED value from the Nios LED PIO export
key_0_db_n  output  1  debounced key 0 to the Nios PIO, active-low
key_1_db_n  output  1  debounced key 1 to the Nios PIO, active-low
switch_db  output  1  debounced switch to the Nios PIO
key_0_press  output  1  one-cycle pulse on a debounced press of key 0
key_1_press  output  1  one-cycle pulse on a debounced press of key 1
led_out  output  1  LED pin drive
led_mode  output  2  current LED owner: 0=NIOS, 1=BLINK, 2=SWITCH

Behaviour:
- One clock domain. Reset is synchronous, active-high, and takes priority over all other logic.
- Reset values:
  - key_0_db_n=1, key_1_db_n=1, switch_db=0
  - key_0_press=0, key_1_press=0
  - led_out=0, led_mode=0 (NIOS)
  - all counters=0
  - synchronizer flops: keys load 1, switch loads 0
- Synchronizer: each raw input passes through a 2-flop synchronizer; s denotes the second-flop output.
- Debounce, per input, independent counter:
  - If s == db, the counter clears.
  - If s != db, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s != db, then on the next edge db <= s and the counter clears.
  - Net latency: a raw change held stable is reflected on db exactly DEBOUNCE_CYCLES+2 edges later.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no db change and clears the counter.
- Press pulse:
  - key_x_press=1 for exactly the one cycle in which key_x_db_n first reads 0 after reading 1 (registered alongside db).
  - No pulse is generated on release.
- LED-mode FSM, states NIOS(0), BLINK(1), SWITCH(2); encoding 3 is unreachable and recovers to NIOS on the next edge.
  - key_1_press advances the state: NIOS->BLINK->SWITCH->NIOS.
  - key_0_press forces NIOS from any state.
  - If both pulses occur in the same cycle, key_0 wins (NIOS).
  - The state updates on the edge after the pulse cycle.
- Blink counter:
  - Cleared and LED phase set to 1 on the edge that enters BLINK.
  - While in BLINK, it counts up; on reaching BLINK_HALF_PERIOD-1 it wraps to 0 and the phase toggles.
  - Held at 0 outside BLINK.
- led_out is registered, one edge after led_mode and its source:
  - NIOS: nios_led
  - BLINK: phase
  - SWITCH: switch_db
- Reset asserted mid-debounce or mid-blink discards partial counts; no pulse is emitted on reset release.
- Held keys: a key held beyond the debounce window yields a single pulse; auto-repeat is never generated.

Test Plan:
Tests run with DEBOUNCE_CYCLES=4 and BLINK_HALF_PERIOD=3.
1. Reset held 3 cycles with key_0_raw_n=0 and switch_raw=1 -> during reset and the first cycle after: key_0_db_n=1, switch_db=0, led_out=0, led_mode=0, no press pulse.
2. key_1_raw_n 1->0 at edge k, held low -> key_1_db_n=0 at edge k+6; key_1_press=1 for exactly that one cycle; led_mode=1 at edge k+7; led_out=1 at edge k+8, then toggles every 3 cycles (1,1,1,0,0,0,1...).
3. key_0_raw_n pulsed low for 3 synchronized cycles, then high -> key_0_db_n stays 1 and key_0_press never asserts.
4. Sequence through modes with switch_raw=1 and nios_led=0:
   - key_1 press twice -> led_mode=2, led_out=1.
   - Third key_1 press -> led_mode=0, led_out=0.
   - Toggle nios_led 0->1 -> led_out=1 one edge later.
5. In BLINK mode, key_0 and key_1 debounced presses land in the same cycle -> led_mode=0 next edge; blink counter held at 0.
6. Reset asserted 2 cycles into a key_1 debounce (counter=2), released with key held low -> key_1_db_n=0 exactly DEBOUNCE_CYCLES+2 edges after release; one key_1_press pulse; led_mode goes 0->1.
